// File: rtl/cart_load_ctrl_if.sv
// Download stream in from hps_io and registered cart-memory write port out.
interface cart_load_ctrl_if #(
   parameter int ADDR_W = 15
);
   logic              ioctl_download;
   logic              ioctl_wr;
   logic [24:0]       ioctl_addr;
   logic [7:0]        ioctl_dout;
   logic              cart_wr;
   logic [ADDR_W-1:0] cart_addr;
   logic [7:0]        cart_data;

   modport master (
      output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
      input  cart_wr, cart_addr, cart_data
   );

   modport slave (
      input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
      output cart_wr, cart_addr, cart_data
   );
endinterface

// File: rtl/cart_load_ctrl.sv
// Cartridge load sequencer: forwards ioctl writes to cart memory, grows the address mask,
// flags oversize images and generates core reset. Optional byte checksum: CART_CHECKSUM_EN.
//
// state | meaning
// IDLE  | power-up, waiting for first download
// LOAD  | download active, core held in reset
// HOLD  | core running, counting toward the skip-logo reset
// PULSE | skip-logo reset asserted
// RUN   | normal operation
module cart_load_ctrl #(
   parameter int ADDR_W     = 15,
   parameter int SKIP_DELAY = 5000000,
   parameter int PULSE_LEN  = 1000
) (
   input  logic              clk_sys,
   input  logic              reset,
   cart_load_ctrl_if.slave   bus,
   input  logic              skip_logo,
   output logic [ADDR_W-1:0] cart_mask,
   output logic              oversize,
   output logic              core_reset,
   output logic              loading
`ifdef CART_CHECKSUM_EN
   ,
   output logic [7:0]        cart_sum
`endif
);

   localparam int CNT_W = (SKIP_DELAY > 1) ? $clog2(SKIP_DELAY) : 1;
   localparam logic [CNT_W-1:0] CNT_START = CNT_W'(SKIP_DELAY - 1);
   localparam logic [CNT_W-1:0] CNT_PULSE = CNT_W'(PULSE_LEN);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      HOLD  = 3'd2,
      PULSE = 3'd3,
      RUN   = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              cart_wr_q, cart_wr_d;
   logic [ADDR_W-1:0] cart_addr_q, cart_addr_d;
   logic [7:0]        cart_data_q, cart_data_d;
   logic [ADDR_W-1:0] mask_q, mask_d;
   logic              ovf_q, ovf_d;
   logic              core_reset_q, core_reset_d;
   logic              loading_q, loading_d;
   logic              in_window;
   logic [ADDR_W-1:0] addr_lo;
`ifdef CART_CHECKSUM_EN
   logic [7:0]        sum_q, sum_d;
`endif

   assign in_window = (bus.ioctl_addr >> ADDR_W) == 25'd0;
   assign addr_lo   = bus.ioctl_addr[ADDR_W-1:0];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cart_wr_d   = 1'b0;
      cart_addr_d = cart_addr_q;
      cart_data_d = cart_data_q;
      mask_d      = mask_q;
      ovf_d       = ovf_q;
`ifdef CART_CHECKSUM_EN
      sum_d       = cart_wr_q ? sum_q + cart_data_q : sum_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.ioctl_download) state_d = LOAD;
         end
         LOAD: begin
            if (bus.ioctl_wr) begin
               if (in_window) begin
                  cart_wr_d   = 1'b1;
                  cart_addr_d = addr_lo;
                  cart_data_d = bus.ioctl_dout;
                  // one bit per write; saturates once every address bit is covered
                  if ((addr_lo & ~mask_q) != '0) mask_d = (mask_q << 1) | ADDR_W'(1);
               end else begin
                  ovf_d = 1'b1;
               end
            end
            if (!bus.ioctl_download) begin
               if (skip_logo) begin
                  state_d = HOLD;
                  cnt_d   = CNT_START;
               end else begin
                  state_d = RUN;
               end
            end
         end
         HOLD: begin
            if (bus.ioctl_download) begin
               state_d = LOAD;
            end else begin
               cnt_d = cnt_q - 1'b1;
               // leave once the decremented count drops below PULSE_LEN
               if (cnt_q <= CNT_PULSE) state_d = PULSE;
            end
         end
         PULSE: begin
            if (bus.ioctl_download) begin
               state_d = LOAD;
            end else if (cnt_q == '0) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RUN: begin
            if (bus.ioctl_download) state_d = LOAD;
         end
         default: state_d = IDLE;
      endcase

      if (state_d == LOAD && state_q != LOAD) begin
         mask_d = '0;
         ovf_d  = 1'b0;
`ifdef CART_CHECKSUM_EN
         sum_d  = 8'd0;
`endif
      end

      core_reset_d = (state_d == LOAD) || (state_d == PULSE);
      loading_d    = (state_d == LOAD);
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         cart_wr_q    <= 1'b0;
         cart_addr_q  <= '0;
         cart_data_q  <= 8'd0;
         mask_q       <= '0;
         ovf_q        <= 1'b0;
         core_reset_q <= 1'b1;
         loading_q    <= 1'b0;
`ifdef CART_CHECKSUM_EN
         sum_q        <= 8'd0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cart_wr_q    <= cart_wr_d;
         cart_addr_q  <= cart_addr_d;
         cart_data_q  <= cart_data_d;
         mask_q       <= mask_d;
         ovf_q        <= ovf_d;
         core_reset_q <= core_reset_d;
         loading_q    <= loading_d;
`ifdef CART_CHECKSUM_EN
         sum_q        <= sum_d;
`endif
      end
   end

   assign bus.cart_wr   = cart_wr_q;
   assign bus.cart_addr = cart_addr_q;
   assign bus.cart_data = cart_data_q;
   assign cart_mask     = mask_q;
   assign oversize      = ovf_q;
   assign core_reset    = core_reset_q;
   assign loading       = loading_q;
`ifdef CART_CHECKSUM_EN
   assign cart_sum      = sum_q;
`endif

endmodule

// File: tb/tb_cart_load_ctrl.sv
// Randomized bench for cart_load_ctrl: write scoreboard plus a mask/oversize/checksum model.
module tb_cart_load_ctrl;
   localparam int ADDR_W     = 15;
   localparam int SKIP_DELAY = 20;
   localparam int PULSE_LEN  = 4;
   localparam int WIN        = 1 << ADDR_W;

   logic              clk_sys = 1'b0;
   logic              reset   = 1'b1;
   logic              skip_logo = 1'b0;
   logic [ADDR_W-1:0] cart_mask;
   logic              oversize, core_reset, loading;
`ifdef CART_CHECKSUM_EN
   logic [7:0]        cart_sum;
`endif

   cart_load_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   cart_load_ctrl #(.ADDR_W(ADDR_W), .SKIP_DELAY(SKIP_DELAY), .PULSE_LEN(PULSE_LEN)) dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .bus        (bus),
      .skip_logo  (skip_logo),
      .cart_mask  (cart_mask),
      .oversize   (oversize),
      .core_reset (core_reset),
      .loading    (loading)
`ifdef CART_CHECKSUM_EN
      ,
      .cart_sum   (cart_sum)
`endif
   );

   always #5 clk_sys = ~clk_sys;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int                cyc;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
   } wr_t;
   wr_t exp_q[$];

   int       m_mask;
   bit       m_ovf;
   bit [7:0] m_sum;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   always @(posedge clk_sys) cyc <= cyc + 1;

   // every cycle: a write is due exactly one cycle after it was accepted, otherwise silence
   always @(negedge clk_sys) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         check_val("cart_wr", 32'(bus.cart_wr), 32'd1);
         check_val("cart_addr", 32'(bus.cart_addr), 32'(exp_q[0].addr));
         check_val("cart_data", 32'(bus.cart_data), 32'(exp_q[0].data));
         void'(exp_q.pop_front());
      end else begin
         check_val("cart_wr_idle", 32'(bus.cart_wr), 32'd0);
      end
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic start_load();
      bus.ioctl_download = 1'b1;
      m_mask = 0;
      m_ovf  = 1'b0;
      m_sum  = 8'd0;
   endtask

   task automatic wr_byte(input int a, input logic [7:0] d);
      wr_t e;
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = 25'(a);
      bus.ioctl_dout = d;
      if (a < WIN) begin
         e.cyc  = cyc + 1;
         e.addr = ADDR_W'(a);
         e.data = d;
         exp_q.push_back(e);
         if (a > m_mask) m_mask = m_mask * 2 + 1;
         m_sum = m_sum + d;
      end else begin
         m_ovf = 1'b1;
      end
      tick();
      bus.ioctl_wr = 1'b0;
   endtask

   task automatic stray_wr();
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = 25'($urandom_range(0, WIN - 1));
      bus.ioctl_dout = 8'($urandom);
      tick();
      bus.ioctl_wr = 1'b0;
   endtask

   task automatic post_checks(input string tag);
      tick();
      @(negedge clk_sys);
      check_val({tag, "_mask"}, 32'(cart_mask), 32'(m_mask));
      check_val({tag, "_oversize"}, 32'(oversize), 32'(m_ovf));
`ifdef CART_CHECKSUM_EN
      check_val({tag, "_sum"}, 32'(cart_sum), 32'(m_sum));
`endif
   endtask

   task automatic rand_load(input string tag, input int n);
      int a;
      start_load();
      tick();
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) tick();
         if ($urandom_range(0, 7) == 0) a = int'($urandom_range(WIN, 25'h1FFFFFF));
         else a = int'($urandom_range(0, WIN - 1));
         wr_byte(a, 8'($urandom));
      end
      bus.ioctl_download = 1'b0;
      skip_logo = 1'b0;
      tick();
      @(negedge clk_sys);
      check_val({tag, "_rst_after"}, 32'(core_reset), 32'd0);
      post_checks(tag);
      stray_wr();
   endtask

   initial begin
      int found;
      bus.ioctl_download = 1'b0;
      bus.ioctl_wr       = 1'b0;
      bus.ioctl_addr     = '0;
      bus.ioctl_dout     = '0;
      m_mask = 0; m_ovf = 1'b0; m_sum = 8'd0;

      repeat (3) tick();
      @(negedge clk_sys);
      check_val("rst_core_reset", 32'(core_reset), 32'd1);
      check_val("rst_mask", 32'(cart_mask), 32'd0);
      check_val("rst_oversize", 32'(oversize), 32'd0);
      check_val("rst_loading", 32'(loading), 32'd0);
      check_val("rst_addr", 32'(bus.cart_addr), 32'd0);
      check_val("rst_data", 32'(bus.cart_data), 32'd0);
`ifdef CART_CHECKSUM_EN
      check_val("rst_sum", 32'(cart_sum), 32'd0);
`endif
      reset = 1'b0;
      tick();
      @(negedge clk_sys);
      check_val("idle_core_reset", 32'(core_reset), 32'd0);

      // sequential 8 KiB image; last byte rides the falling edge of download
      start_load();
      tick();
      @(negedge clk_sys);
      check_val("load_core_reset", 32'(core_reset), 32'd1);
      check_val("load_loading", 32'(loading), 32'd1);
      for (int i = 0; i < 8191; i++) wr_byte(i, 8'(i));
      bus.ioctl_download = 1'b0;
      wr_byte(8191, 8'(8191));
      @(negedge clk_sys);
      check_val("seq_core_reset_exit", 32'(core_reset), 32'd0);
      check_val("seq_loading_exit", 32'(loading), 32'd0);
      post_checks("seq8k");
      stray_wr();

      // full window then one byte past it
      start_load();
      tick();
      for (int i = 0; i < WIN; i++) wr_byte(i, 8'($urandom));
      wr_byte(WIN, 8'hA5);
      bus.ioctl_download = 1'b0;
      tick();
      post_checks("full");

      // skip-logo sequence: low for SKIP_DELAY-PULSE_LEN, high for PULSE_LEN, then low
      start_load();
      tick();
      for (int i = 0; i < 10; i++) wr_byte(int'($urandom_range(0, 255)), 8'($urandom));
      bus.ioctl_download = 1'b0;
      skip_logo = 1'b1;
      tick();
      for (int i = 0; i < SKIP_DELAY + 8; i++) begin
         @(negedge clk_sys);
         check_val("skip_core_reset", 32'(core_reset),
                   (i >= SKIP_DELAY - PULSE_LEN && i < SKIP_DELAY) ? 32'd1 : 32'd0);
      end
      post_checks("skip");

      // new download arriving in the second PULSE cycle
      start_load();
      tick();
      for (int i = 0; i < 20; i++) wr_byte(i * 7, 8'($urandom));
      bus.ioctl_download = 1'b0;
      skip_logo = 1'b1;
      tick();
      found = 0;
      for (int i = 0; i < 3 * SKIP_DELAY && found == 0; i++) begin
         @(negedge clk_sys);
         if (core_reset) found = 1;
      end
      check_val("abort_pulse_seen", 32'(found), 32'd1);
      tick();
      @(negedge clk_sys);
      check_val("abort_pulse2_rst", 32'(core_reset), 32'd1);
      start_load();
      skip_logo = 1'b0;
      tick();
      @(negedge clk_sys);
      check_val("abort_core_reset", 32'(core_reset), 32'd1);
      check_val("abort_loading", 32'(loading), 32'd1);
      check_val("abort_mask", 32'(cart_mask), 32'd0);
      for (int i = 0; i < 40; i++) wr_byte(i, 8'($urandom));
      bus.ioctl_download = 1'b0;
      tick();
      post_checks("abort");

      // reset in the middle of a load, then a fresh load
      start_load();
      tick();
      for (int i = 0; i < 100; i++) wr_byte(i, 8'($urandom));
      reset = 1'b1;
      bus.ioctl_download = 1'b0;
      tick();
      @(negedge clk_sys);
      check_val("midrst_core_reset", 32'(core_reset), 32'd1);
      check_val("midrst_mask", 32'(cart_mask), 32'd0);
      check_val("midrst_loading", 32'(loading), 32'd0);
      check_val("midrst_oversize", 32'(oversize), 32'd0);
      reset = 1'b0;
      tick();
      rand_load("fresh", 60);

      // checksum pattern
      start_load();
      tick();
      wr_byte(0, 8'hFF);
      wr_byte(1, 8'h02);
      wr_byte(2, 8'h10);
      bus.ioctl_download = 1'b0;
      tick();
      post_checks("sum3");

      for (int k = 0; k < 4; k++) rand_load("rand", int'($urandom_range(1, 300)));

      repeat (3) tick();
      check_val("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
